// File: rtl/dram32x1d_bist_driver.sv
// Two-pass write/readback march driver for a RAM32X1D (pattern, then inverted pattern).
// Optional macro DRAM_BIST_LOOP_EN: after one start the march repeats forever and results accumulate.
module dram32x1d_bist_driver #(
    parameter logic [31:0] PATTERN = 32'hA5C3_0F96,
    parameter int          ERR_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [4:0]       ram_a,
    output logic [4:0]       ram_dpra,
    output logic             ram_d,
    output logic             ram_we,
    input  logic             ram_spo,
    input  logic             ram_dpo,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [4:0]       fail_addr
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE0 = 3'd1,
        ST_READ0  = 3'd2,
        ST_WRITE1 = 3'd3,
        ST_READ1  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        if (v == ERR_MAX) begin
            return v;
        end else begin
            return v + ERR_W'(1);
        end
    endfunction

    state_t           state_r, state_s;
    logic [4:0]       addr_r;
    logic [ERR_W-1:0] err_r, err_next_s;
    logic [4:0]       fail_r;
    logic             seen_r, pass_r;
    logic             in_write_s, in_read_s, exp_s, launch_s, finish_s, last_s, mismatch_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode plus per-state write/read qualifiers and expected bit.
    always_comb begin
        state_s    = state_r;
        in_write_s = 1'b0;
        in_read_s  = 1'b0;
        exp_s      = 1'b0;
        launch_s   = 1'b0;
        finish_s   = 1'b0;
        last_s     = (addr_r == 5'd31);
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s  = ST_WRITE0;
                    launch_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WRITE0: begin
                in_write_s = 1'b1;
                exp_s      = PATTERN[addr_r];
                state_s    = last_s ? ST_READ0 : ST_WRITE0;
            end
            ST_READ0: begin
                in_read_s = 1'b1;
                exp_s     = PATTERN[addr_r];
                state_s   = last_s ? ST_WRITE1 : ST_READ0;
            end
            ST_WRITE1: begin
                in_write_s = 1'b1;
                exp_s      = ~PATTERN[addr_r];
                state_s    = last_s ? ST_READ1 : ST_WRITE1;
            end
            ST_READ1: begin
                in_read_s = 1'b1;
                exp_s     = ~PATTERN[addr_r];
                finish_s  = last_s;
                state_s   = last_s ? ST_DONE : ST_READ1;
            end
            ST_DONE: begin
`ifdef DRAM_BIST_LOOP_EN
                state_s = ST_WRITE0;
`else
                state_s = ST_IDLE;
`endif
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Both read ports are compared in the same cycle since the RAM read is asynchronous.
    assign mismatch_s = in_read_s & ((ram_spo != exp_s) | (ram_dpo != exp_s));
    assign err_next_s = mismatch_s ? sat_inc(err_r) : err_r;

    // Address counter, error accounting and sticky pass result.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r <= 5'd0;
            err_r  <= '0;
            fail_r <= 5'd0;
            seen_r <= 1'b0;
            pass_r <= 1'b0;
        end else begin
            // Counter wraps at 31 on the same edge the state advances, so each phase starts at 0.
            addr_r <= (in_write_s | in_read_s) ? addr_r + 5'd1 : 5'd0;
            if (launch_s) begin
                err_r  <= '0;
                fail_r <= 5'd0;
                seen_r <= 1'b0;
            end else begin
                err_r <= err_next_s;
                if (mismatch_s && !seen_r) begin
                    fail_r <= addr_r;
                    seen_r <= 1'b1;
                end
            end
            if (finish_s) begin
                pass_r <= (err_next_s == '0);
            end
        end
    end

    assign ram_a     = addr_r;
    assign ram_dpra  = addr_r;
    assign ram_d     = in_write_s & exp_s;
    assign ram_we    = in_write_s & ~rst;
    assign busy      = in_write_s | in_read_s;
    assign done      = (state_r == ST_DONE);
    assign pass      = pass_r;
    assign err_count = err_r;
    assign fail_addr = fail_r;

endmodule

// File: tb/tb_dram32x1d_bist_driver.sv
// Scoreboard bench: fault-injecting RAM32X1D model, per-run expectations from a march-level reference.
module tb_dram32x1d_bist_driver;

    localparam logic [31:0] PAT = 32'hA5C3_0F96;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [4:0] ram_a, ram_dpra, fail_addr;
    logic       ram_d, ram_we, ram_spo, ram_dpo, busy, done, pass;
    logic [5:0] err_count;

    dram32x1d_bist_driver dut (
        .clk(clk), .rst(rst), .start(start),
        .ram_a(ram_a), .ram_dpra(ram_dpra), .ram_d(ram_d), .ram_we(ram_we),
        .ram_spo(ram_spo), .ram_dpo(ram_dpo),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_addr(fail_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model with per-cell stuck faults and optional DPO inversion.
    logic [31:0] mem = 32'h0;
    logic [31:0] f_mask = 32'h0, f_val = 32'h0;
    logic        f_inv = 1'b0;
    always @(posedge clk) if (ram_we) mem[ram_a] <= ram_d;
    assign ram_spo = f_mask[ram_a] ? f_val[ram_a] : mem[ram_a];
    assign ram_dpo = (f_mask[ram_dpra] ? f_val[ram_dpra] : mem[ram_dpra]) ^ f_inv;

    typedef struct {
        int         edge0;
        logic [5:0] err;
        logic [4:0] fail;
        logic       pass;
    } exp_t;

    exp_t q[$];
    int checks = 0, failures = 0;
    logic       exp_pass = 1'b0;
    logic [5:0] exp_err = 6'd0;
    logic [4:0] exp_fail = 5'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: every cell written with the pass pattern then read on both ports.
    function automatic exp_t model(input logic [31:0] mask, input logic [31:0] sval,
                                   input logic inv, input int e);
        exp_t r;
        int cnt = 0, first = -1;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 32; i++) begin
                logic w, s, d;
                w = PAT[i] ^ (p == 1);
                s = mask[i] ? sval[i] : w;
                d = inv ? ~s : s;
                if (s != w || d != w) begin
                    if (first < 0) first = i;
                    cnt++;
                end
            end
        end
        r.edge0 = e;
        r.err   = (cnt > 63) ? 6'd63 : 6'(cnt);
        r.fail  = (first < 0) ? 5'd0 : 5'(first);
        r.pass  = (cnt == 0);
        return r;
    endfunction

    // Monitor: cycle k of a run is the interval following edge edge0+k-1.
    always @(negedge clk) begin : mon
        int off, a, seg;
        logic wr, ed;
        off = (q.size() == 0) ? 0 : (cyc - q[0].edge0 + 1);
        if (rst) begin
            check("we_during_rst", {31'd0, ram_we}, 32'd0);
        end else if (off < 1) begin
            check("idle", {17'd0, busy, done, ram_we, pass, err_count, fail_addr},
                  {17'd0, 3'b000, exp_pass, exp_err, exp_fail});
        end else if (off <= 128) begin
            seg = (off - 1) / 32;
            a   = (off - 1) % 32;
            wr  = (seg == 0) || (seg == 2);
            ed  = PAT[a] ^ (seg >= 2);
            check("run_cycle", {17'd0, busy, done, ram_we, ram_d, ram_a, ram_dpra, pass},
                  {17'd0, 1'b1, 1'b0, wr, wr & ed, 5'(a), 5'(a), exp_pass});
        end else begin
            check("done_result", {17'd0, busy, done, ram_we, pass, err_count, fail_addr},
                  {17'd0, 1'b0, 1'b1, 1'b0, q[0].pass, q[0].err, q[0].fail});
            exp_pass = q[0].pass;
            exp_err  = q[0].err;
            exp_fail = q[0].fail;
            void'(q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 400) begin
            step();
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL run_timeout: %0d runs pending, expected 0", q.size());
            q.delete();
        end
        repeat (3) step();
    endtask

    task automatic launch(input logic [31:0] mask, input logic [31:0] sval, input logic inv);
        f_mask = mask;
        f_val  = sval;
        f_inv  = inv;
        start  = 1'b1;
        step();
        start  = 1'b0;
        q.push_back(model(mask, sval, inv, cyc));
    endtask

    task automatic run(input logic [31:0] mask, input logic [31:0] sval, input logic inv);
        launch(mask, sval, inv);
        wait_idle();
    endtask

    task automatic check_reset_state(input string name);
        check(name, {9'd0, busy, done, ram_we, ram_d, pass, ram_a, ram_dpra, err_count, fail_addr},
              32'd0);
    endtask

    task automatic rst_at(input int cycle_no);
        int e;
        launch(32'h0, 32'h0, 1'b0);
        e = cyc;
        while (cyc - e + 1 < cycle_no) step();
        rst = 1'b1;
        q.delete();
        step();
        rst = 1'b0;
        exp_pass = 1'b0;
        exp_err  = 6'd0;
        exp_fail = 5'd0;
        check_reset_state("after_mid_rst");
        repeat (3) step();
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        check_reset_state("reset_state");
        step();

        run(32'h0, 32'h0, 1'b0);
        run(32'h0000_0002, 32'h0, 1'b0);
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run(32'h0, 32'h0, 1'b1);

        rst_at(40);
        run(32'h0, 32'h0, 1'b0);
        rst_at(10);
        run(32'h0, 32'h0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            logic [31:0] m;
            m = (k == 0) ? (32'h1 << $urandom_range(0, 31)) : ($urandom & $urandom & $urandom);
            run(m, $urandom, ($urandom_range(0, 4) == 0));
        end

        // start held high for 200 cycles: back-to-back runs at edges e and e+130 only.
        begin
            int e;
            f_mask = 32'h0;
            f_val  = 32'h0;
            f_inv  = 1'b0;
            start  = 1'b1;
            step();
            e = cyc;
            q.push_back(model(32'h0, 32'h0, 1'b0, e));
            q.push_back(model(32'h0, 32'h0, 1'b0, e + 130));
            repeat (199) step();
            start = 1'b0;
            wait_idle();
            repeat (20) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
